// File: rtl/led_pattern_sequencer_if.sv
// Command handshake (valid/ready plus pattern mode) between a controller
// and the LED pattern sequencer.
interface led_pattern_sequencer_if;
  logic       cmd_valid;
  logic [1:0] cmd_mode;
  logic       cmd_ready;

  modport master (
    output cmd_valid,
    output cmd_mode,
    input  cmd_ready
  );

  modport slave (
    input  cmd_valid,
    input  cmd_mode,
    output cmd_ready
  );
endinterface

// File: rtl/led_pattern_sequencer.sv
// Steps a selectable LED pattern once per rising edge of a slow, asynchronous
// tick, with repeat counting, pause and a valid/ready command interface.
module led_pattern_sequencer #(
  parameter int LED_W       = 8,
  parameter int SYNC_STAGES = 2,
  parameter int REPEAT      = 0
) (
  input  logic                   clk_in,
  input  logic                   rst_n,
  input  logic                   tick_in,
  led_pattern_sequencer_if.slave cmd,
  input  logic                   run_en,
  output logic [LED_W-1:0]       led,
  output logic                   step_pulse,
  output logic                   busy,
  output logic                   done
);

  localparam int CNT_W = (REPEAT < 1) ? 1 : $clog2(REPEAT + 1);
  localparam logic [CNT_W:0] REP_VAL = (CNT_W + 1)'(REPEAT);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LOAD,
    ST_RUN,
    ST_PAUSE
  } state_t;

  // tick_in is a level from another clock: resynchronise, then edge-detect
  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   edge_q, edge_d;
  logic                   step_q, step_d;

  state_t           state_q, state_d;
  logic [1:0]       mode_q, mode_d;
  logic [LED_W-1:0] led_q, led_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             done_q, done_d;

  logic             accept;
  logic             ready_w;
  logic [LED_W-1:0] init_led;
  logic [LED_W-1:0] adv_led;
  logic [CNT_W:0]   cnt_plus;

  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], tick_in};
    edge_d = sync_q[SYNC_STAGES-1];
    step_d = sync_q[SYNC_STAGES-1] & ~edge_q;
  end

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
      edge_q <= 1'b0;
      step_q <= 1'b0;
    end else begin
      sync_q <= sync_d;
      edge_q <= edge_d;
      step_q <= step_d;
    end
  end

  always_comb begin
    init_led = '0;
    case (mode_q)
      2'd1:    init_led = '1;
      2'd2:    init_led = {{(LED_W-1){1'b0}}, 1'b1};
      default: init_led = '0;
    endcase
  end

  always_comb begin
    adv_led = led_q;
    case (mode_q)
      2'd1:    adv_led = ~led_q;
      2'd2:    adv_led = {led_q[LED_W-2:0], led_q[LED_W-1]};
      2'd3:    adv_led = led_q + LED_W'(1);
      default: adv_led = led_q;
    endcase
  end

  assign cnt_plus = {1'b0, cnt_q} + (CNT_W + 1)'(1);
  assign ready_w  = (state_q != ST_LOAD);
  assign accept   = cmd.cmd_valid & ready_w;

  // A new command always wins over a coincident step and aborts the pattern
  always_comb begin
    state_d = state_q;
    mode_d  = mode_q;
    led_d   = led_q;
    cnt_d   = cnt_q;
    done_d  = 1'b0;
    if (accept) begin
      mode_d  = cmd.cmd_mode;
      state_d = ST_LOAD;
    end else begin
      case (state_q)
        ST_LOAD: begin
          led_d = init_led;
          cnt_d = '0;
          if (mode_q == 2'd0) begin
            state_d = ST_IDLE;
          end else if (run_en) begin
            state_d = ST_RUN;
          end else begin
            state_d = ST_PAUSE;
          end
        end
        ST_RUN: begin
          if (!run_en) begin
            state_d = ST_PAUSE;
          end else if (step_q) begin
            led_d = adv_led;
            // Returning to the start value marks one complete period
            if (adv_led == init_led) begin
              if (cnt_q != CNT_MAX) begin
                cnt_d = cnt_plus[CNT_W-1:0];
              end
              if ((REPEAT != 0) && (cnt_plus == REP_VAL)) begin
                done_d  = 1'b1;
                state_d = ST_IDLE;
              end
            end
          end
        end
        ST_PAUSE: begin
          if (run_en) begin
            state_d = ST_RUN;
          end
        end
        default: begin
          state_d = state_q;
        end
      endcase
    end
  end

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      mode_q  <= 2'd0;
      led_q   <= '0;
      cnt_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      led_q   <= led_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
    end
  end

  assign cmd.cmd_ready = ready_w;
  assign led           = led_q;
  assign step_pulse    = step_q;
  assign busy          = (state_q != ST_IDLE);
  assign done          = done_q;

endmodule

// File: tb/tb_led_pattern_sequencer.sv
// Bench for led_pattern_sequencer: two instances (REPEAT=2 and REPEAT=0) share
// stimulus and are checked every cycle against a step-index reference model.
module tb_led_pattern_sequencer;

  localparam int S_IDLE  = 0;
  localparam int S_LOAD  = 1;
  localparam int S_RUN   = 2;
  localparam int S_PAUSE = 3;

  logic       clk_in    = 1'b0;
  logic       rst_n     = 1'b0;
  logic       tick_in   = 1'b0;
  logic       run_en    = 1'b0;
  logic       cmd_valid = 1'b0;
  logic [1:0] cmd_mode  = 2'd0;

  logic [7:0] led_a, led_b;
  logic       step_a, step_b, busy_a, busy_b, done_a, done_b;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk_in = ~clk_in;

  led_pattern_sequencer_if if_a ();
  led_pattern_sequencer_if if_b ();

  assign if_a.cmd_valid = cmd_valid;
  assign if_a.cmd_mode  = cmd_mode;
  assign if_b.cmd_valid = cmd_valid;
  assign if_b.cmd_mode  = cmd_mode;

  led_pattern_sequencer #(.LED_W(8), .SYNC_STAGES(2), .REPEAT(2)) dut_a (
    .clk_in(clk_in), .rst_n(rst_n), .tick_in(tick_in), .cmd(if_a.slave),
    .run_en(run_en), .led(led_a), .step_pulse(step_a), .busy(busy_a), .done(done_a)
  );

  led_pattern_sequencer #(.LED_W(8), .SYNC_STAGES(2), .REPEAT(0)) dut_b (
    .clk_in(clk_in), .rst_n(rst_n), .tick_in(tick_in), .cmd(if_b.slave),
    .run_en(run_en), .led(led_b), .step_pulse(step_b), .busy(busy_b), .done(done_b)
  );

  // Reference model: the LED value is a pure function of mode and the number
  // of steps taken since the last load.
  int         m_state [2];
  int         m_mode  [2];
  int         m_k     [2];
  logic [7:0] m_led   [2];
  logic       m_done  [2];
  logic       m_step;
  logic [3:0] hist;

  function automatic int rep(input int i);
    return (i == 0) ? 2 : 0;
  endfunction

  function automatic int period(input int mode);
    case (mode)
      1:       return 2;
      2:       return 8;
      3:       return 256;
      default: return 1;
    endcase
  endfunction

  function automatic logic [7:0] pat(input int mode, input int k);
    case (mode)
      1:       return ((k % 2) == 0) ? 8'hFF : 8'h00;
      2:       return 8'(1 << (k % 8));
      3:       return 8'(k % 256);
      default: return 8'h00;
    endcase
  endfunction

  task automatic mdl_reset();
    for (int i = 0; i < 2; i++) begin
      m_state[i] = S_IDLE;
      m_mode[i]  = 0;
      m_k[i]     = 0;
      m_led[i]   = 8'h00;
      m_done[i]  = 1'b0;
    end
    m_step = 1'b0;
    hist   = 4'b0000;
  endtask

  task automatic mdl_clock();
    logic step_used;
    logic acc;
    int   len;
    step_used = m_step;
    hist      = {hist[2:0], tick_in};
    m_step    = hist[2] & ~hist[3];
    for (int i = 0; i < 2; i++) begin
      m_done[i] = 1'b0;
      acc = cmd_valid && (m_state[i] != S_LOAD);
      if (acc) begin
        m_mode[i]  = int'(cmd_mode);
        m_state[i] = S_LOAD;
      end else begin
        case (m_state[i])
          S_LOAD: begin
            m_k[i]     = 0;
            m_led[i]   = pat(m_mode[i], 0);
            m_state[i] = (m_mode[i] == 0) ? S_IDLE : (run_en ? S_RUN : S_PAUSE);
          end
          S_RUN: begin
            if (!run_en) begin
              m_state[i] = S_PAUSE;
            end else if (step_used) begin
              m_k[i]   = m_k[i] + 1;
              len      = period(m_mode[i]);
              m_led[i] = pat(m_mode[i], m_k[i] % len);
              if (rep(i) != 0 && m_k[i] == rep(i) * len) begin
                m_done[i]  = 1'b1;
                m_state[i] = S_IDLE;
              end
            end
          end
          S_PAUSE: if (run_en) m_state[i] = S_RUN;
          default: ;
        endcase
      end
    end
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check_all();
    chk("a.led",   32'(led_a),          32'(m_led[0]));
    chk("a.step",  32'(step_a),         32'(m_step));
    chk("a.busy",  32'(busy_a),         32'(m_state[0] != S_IDLE));
    chk("a.done",  32'(done_a),         32'(m_done[0]));
    chk("a.ready", 32'(if_a.cmd_ready), 32'(m_state[0] != S_LOAD));
    chk("b.led",   32'(led_b),          32'(m_led[1]));
    chk("b.step",  32'(step_b),         32'(m_step));
    chk("b.busy",  32'(busy_b),         32'(m_state[1] != S_IDLE));
    chk("b.done",  32'(done_b),         32'(m_done[1]));
    chk("b.ready", 32'(if_b.cmd_ready), 32'(m_state[1] != S_LOAD));
  endtask

  // Inputs change only at the falling edge; outputs are checked there too
  task automatic cycle();
    @(posedge clk_in);
    if (rst_n) mdl_clock();
    else       mdl_reset();
    @(negedge clk_in);
    check_all();
  endtask

  task automatic do_step();
    tick_in = 1'b1;
    cycle();
    cycle();
    tick_in = 1'b0;
    cycle();
    cycle();
  endtask

  task automatic accept_cmd(input logic [1:0] mode);
    cmd_valid = 1'b1;
    cmd_mode  = mode;
    cycle();
    cmd_valid = 1'b0;
    cycle();
  endtask

  typedef struct {
    int         mode;
    logic       run;
    int         nsteps;
    logic [7:0] exp_led;
    logic       exp_busy;
  } vec_t;

  vec_t tbl [7];
  int   npulse;
  int   first;

  initial begin
    tbl[0] = '{1, 1'b1,  3, 8'h00, 1'b1};
    tbl[1] = '{2, 1'b1,  5, 8'h20, 1'b1};
    tbl[2] = '{3, 1'b1,  7, 8'h07, 1'b1};
    tbl[3] = '{1, 1'b0,  4, 8'hFF, 1'b1};
    tbl[4] = '{0, 1'b1,  2, 8'h00, 1'b0};
    tbl[5] = '{2, 1'b1, 10, 8'h04, 1'b1};
    tbl[6] = '{3, 1'b1,  0, 8'h00, 1'b1};

    mdl_reset();
    repeat (3) cycle();
    chk("rst.led",   32'(led_a), 32'h00);
    chk("rst.busy",  32'(busy_a), 32'h0);
    chk("rst.ready", 32'(if_a.cmd_ready), 32'h1);
    chk("rst.done",  32'(done_b), 32'h0);
    rst_n  = 1'b1;
    run_en = 1'b1;
    repeat (3) cycle();

    // Held-high tick gives a single pulse three cycles after the rise
    tick_in = 1'b1;
    npulse  = 0;
    first   = -1;
    for (int c = 1; c <= 100; c++) begin
      cycle();
      if (step_a) begin
        npulse++;
        if (first < 0) first = c;
      end
    end
    chk("t2.npulse", 32'(npulse), 32'd1);
    chk("t2.delay",  32'(first),  32'd3);
    tick_in = 1'b0;
    repeat (4) cycle();
    tick_in = 1'b1;
    npulse  = 0;
    repeat (10) begin
      cycle();
      if (step_a) npulse++;
    end
    chk("t2.second", 32'(npulse), 32'd1);
    tick_in = 1'b0;
    repeat (4) cycle();

    for (int r = 0; r < 7; r++) begin
      run_en = tbl[r].run;
      accept_cmd(2'(tbl[r].mode));
      for (int s = 0; s < tbl[r].nsteps; s++) do_step();
      chk($sformatf("tbl%0d.led", r),  32'(led_b),  32'(tbl[r].exp_led));
      chk($sformatf("tbl%0d.busy", r), 32'(busy_b), 32'(tbl[r].exp_busy));
    end
    run_en = 1'b1;

    // REPEAT=2, walking one: done after two full periods
    accept_cmd(2'd2);
    chk("t3.init", 32'(led_a), 32'h01);
    for (int s = 1; s <= 16; s++) begin
      do_step();
      chk($sformatf("t3.step%0d", s), 32'(led_a), 32'(8'h01 << (s % 8)));
    end
    chk("t3.done", 32'(done_a), 32'h1);
    chk("t3.busy", 32'(busy_a), 32'h0);
    cycle();
    chk("t3.done_low", 32'(done_a), 32'h0);

    // REPEAT=0, binary count wraps through FF -> 00
    accept_cmd(2'd3);
    repeat (255) do_step();
    chk("t4.ff", 32'(led_b), 32'hFF);
    do_step();
    chk("t4.wrap", 32'(led_b), 32'h00);
    do_step();
    chk("t4.cont", 32'(led_b), 32'h01);
    chk("t4.busy", 32'(busy_b), 32'h1);

    // Pause holds the pattern
    accept_cmd(2'd1);
    run_en = 1'b0;
    cycle();
    repeat (5) do_step();
    chk("t5.hold", 32'(led_b), 32'hFF);
    run_en = 1'b1;
    cycle();
    cycle();
    do_step();
    chk("t5.inv", 32'(led_b), 32'h00);

    // Command coincident with a step: command wins
    accept_cmd(2'd3);
    repeat (5) do_step();
    chk("t6.pre", 32'(led_b), 32'h05);
    tick_in = 1'b1;
    cycle();
    cycle();
    tick_in = 1'b0;
    cycle();
    chk("t6.pulse", 32'(step_b), 32'h1);
    cmd_valid = 1'b1;
    cmd_mode  = 2'd2;
    cycle();
    cmd_valid = 1'b0;
    chk("t6.load_led",   32'(led_b), 32'h05);
    chk("t6.load_ready", 32'(if_b.cmd_ready), 32'h0);
    cycle();
    chk("t6.led",   32'(led_b), 32'h01);
    chk("t6.ready", 32'(if_b.cmd_ready), 32'h1);
    chk("t6.done",  32'(done_b), 32'h0);

    // Asynchronous reset mid-run with tick held high through release
    repeat (4) do_step();
    chk("t1.pre", 32'(led_b), 32'h10);
    #2;
    rst_n   = 1'b0;
    tick_in = 1'b1;
    mdl_reset();
    #1;
    chk("t1.led",   32'(led_b), 32'h00);
    chk("t1.busy",  32'(busy_b), 32'h0);
    chk("t1.ready", 32'(if_b.cmd_ready), 32'h1);
    cycle();
    cycle();
    rst_n  = 1'b1;
    npulse = 0;
    first  = -1;
    for (int c = 1; c <= 8; c++) begin
      cycle();
      if (step_b) begin
        npulse++;
        if (first < 0) first = c;
      end
    end
    chk("t1.npulse", 32'(npulse), 32'd1);
    chk("t1.delay",  32'(first),  32'd3);

    // Randomised traffic against the model
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 3) == 0) tick_in = ~tick_in;
      cmd_valid = ($urandom_range(0, 19) == 0);
      cmd_mode  = 2'($urandom_range(0, 3));
      run_en    = ($urandom_range(0, 9) != 0);
      if (i == 1500) begin
        rst_n = 1'b0;
        mdl_reset();
      end else begin
        rst_n = 1'b1;
      end
      cycle();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
